// File: rtl/tilt_div_scheduler.sv
// Shares one valid/ready divider between the X and Y tilt axes and turns each
// magnitude into a per-axis tick rate. Define MAG_DEADBAND_EN to stop below DEADBAND.

module tilt_tick_cnt #(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [CNTR_WIDTH-1:0] period,
  output logic                  tick
);
  logic [CNTR_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || period == '0) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == period) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNTR_WIDTH'(1);
      tick <= 1'b0;
    end
  end
endmodule

module tilt_div_scheduler #(
  parameter int CLK_FREQUENCY_HZ = 100000000,
  parameter int MAG_WIDTH        = 8,
  parameter int CNTR_WIDTH       = 32,
  parameter int DIV_TIMEOUT      = 64,
  parameter int DEADBAND         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MAG_WIDTH-1:0]  x_mag,
  input  logic [MAG_WIDTH-1:0]  y_mag,
  output logic                  div_tvalid,
  input  logic                  div_tready,
  output logic [MAG_WIDTH-1:0]  div_divisor,
  output logic [CNTR_WIDTH-1:0] div_dividend,
  input  logic                  div_result_valid,
  input  logic [CNTR_WIDTH-1:0] div_quotient,
  output logic [CNTR_WIDTH-1:0] x_period,
  output logic [CNTR_WIDTH-1:0] y_period,
  output logic                  tick_x,
  output logic                  tick_y,
  output logic                  busy,
  output logic                  div_error
);
  localparam int   NUM_AXES = 2;
  localparam int   WCW      = $clog2(DIV_TIMEOUT + 1);
  localparam logic AX_Y     = 1'b1;

  if (DIV_TIMEOUT < 1 || DEADBAND < 0) begin : g_bad_param
    $error("tilt_div_scheduler: DIV_TIMEOUT must be >= 1 and DEADBAND >= 0");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
  state_t state_q, state_d;

  logic [NUM_AXES-1:0][MAG_WIDTH-1:0]  mag, cur;
  logic [NUM_AXES-1:0][CNTR_WIDTH-1:0] period;
  logic [NUM_AXES-1:0]                 pending, commit, tick;
  logic [MAG_WIDTH-1:0]                snap, grant_mag;
  logic [CNTR_WIDTH-1:0]               quot;
  logic [WCW-1:0]                      wait_cnt;
  logic                                grant, grant_q, last_grant, grant_stop, timeout;

  assign mag = {y_mag, x_mag};

  // On a tie the axis that was not served last wins.
  assign grant     = (&pending) ? ~last_grant : ~pending[0];
  assign grant_mag = mag[grant];
`ifdef MAG_DEADBAND_EN
  assign grant_stop = (grant_mag < MAG_WIDTH'(DEADBAND));
`else
  assign grant_stop = (grant_mag == '0);
`endif
  assign timeout = (wait_cnt == WCW'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = '0;
    case (state_q)
      IDLE: if (|pending) begin
        if (grant_stop) commit[grant] = 1'b1;
        else            state_d = ISSUE;
      end
      ISSUE:  if (div_tvalid && div_tready) state_d = WAIT;
      WAIT: begin
        if (div_result_valid) state_d = COMMIT;
        else if (timeout)     state_d = IDLE;
      end
      COMMIT: begin
        commit[grant_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      cur        <= '0;
      period     <= '0;
      snap       <= '0;
      quot       <= '0;
      wait_cnt   <= '0;
      grant_q    <= 1'b0;
      last_grant <= AX_Y;
      div_tvalid <= 1'b0;
      div_error  <= 1'b0;
    end else begin
      for (int a = 0; a < NUM_AXES; a++)
        if (mag[a] != cur[a]) pending[a] <= 1'b1;
      case (state_q)
        IDLE: if (|pending) begin
          grant_q <= grant;
          snap    <= grant_mag;
          if (grant_stop) begin
            cur[grant]     <= grant_mag;
            period[grant]  <= '0;
            pending[grant] <= 1'b0;
          end
        end
        ISSUE: begin
          // Registered valid: raised one cycle into ISSUE, dropped on handshake.
          div_tvalid <= ~(div_tvalid & div_tready);
          wait_cnt   <= '0;
        end
        WAIT: begin
          if (div_result_valid) begin
            quot <= div_quotient;
          end else if (timeout) begin
            div_error  <= 1'b1;
            last_grant <= grant_q;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        COMMIT: begin
          period[grant_q]  <= (quot == '0) ? '0 : quot - CNTR_WIDTH'(1);
          cur[grant_q]     <= snap;
          last_grant       <= grant_q;
          // Magnitude moved while dividing: keep pending so it is recomputed.
          pending[grant_q] <= (mag[grant_q] != snap);
        end
        default: ;
      endcase
    end
  end

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    tilt_tick_cnt #(.CNTR_WIDTH(CNTR_WIDTH)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (commit[a]),
      .period (period[a]),
      .tick   (tick[a])
    );
  end

  assign div_divisor  = snap;
  assign div_dividend = CNTR_WIDTH'(CLK_FREQUENCY_HZ);
  assign x_period     = period[0];
  assign y_period     = period[1];
  assign tick_x       = tick[0];
  assign tick_y       = tick[1];
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_tilt_div_scheduler.sv
// Directed bench for tilt_div_scheduler with a 4-cycle-latency divider model.
module tb_tilt_div_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  x_mag = '0, y_mag = '0;
  logic        div_tvalid, div_tready = 1'b1;
  logic [7:0]  div_divisor;
  logic [31:0] div_dividend;
  logic        div_result_valid = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] x_period, y_period;
  logic        tick_x, tick_y, busy, div_error;

  int errors = 0, checks = 0;
  int hs_count = 0, res_count = 0, lat = 0;
  logic [7:0]  hs_div [0:63];
  logic [31:0] pend_q = '0;
  bit drop_result = 1'b0;

  tilt_div_scheduler #(.CLK_FREQUENCY_HZ(1000)) dut (
    .clk(clk), .reset(reset), .x_mag(x_mag), .y_mag(y_mag),
    .div_tvalid(div_tvalid), .div_tready(div_tready), .div_divisor(div_divisor),
    .div_dividend(div_dividend), .div_result_valid(div_result_valid),
    .div_quotient(div_quotient), .x_period(x_period), .y_period(y_period),
    .tick_x(tick_x), .tick_y(tick_y), .busy(busy), .div_error(div_error)
  );

  always #5 clk = ~clk;

  // Divider model: sees the handshake before the edge that takes it and
  // presents the quotient for sampling 4 edges later.
  always @(negedge clk) begin
    div_result_valid = 1'b0;
    if (lat > 0) begin
      lat--;
      if (lat == 0 && !drop_result) begin
        div_result_valid = 1'b1;
        div_quotient     = pend_q;
        res_count++;
      end
    end
    if (div_tvalid && div_tready) begin
      hs_div[hs_count] = div_divisor;
      hs_count++;
      pend_q = 32'(1000 / int'(div_divisor));
      lat    = 4;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; x_mag = '0; y_mag = '0; div_tready = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    int base, nticks, nvalid;
    // Reset state
    step(3);
    check("rst_tvalid", div_tvalid, 0);
    check("rst_divisor", div_divisor, 0);
    check("rst_busy", busy, 0);
    check("rst_xper", x_period, 0);
    check("rst_yper", y_period, 0);
    check("rst_tick", {tick_y, tick_x}, 0);
    check("rst_err", div_error, 0);
    check("dividend", div_dividend, 1000);
    reset = 1'b0;

    // A: x 0->10, latency, period 99, tick spacing 100
    base = hs_count;
    x_mag = 8'd10;
    step(1); check("a_busy_p1", busy, 0);
    step(1); check("a_busy_p2", busy, 1);
             check("a_tvalid_p2", div_tvalid, 0);
    step(1); check("a_tvalid_p3", div_tvalid, 1);
             check("a_divisor", div_divisor, 10);
    step(1); check("a_tvalid_hs", div_tvalid, 0);
             check("a_hs_cnt", hs_count - base, 1);
    step(4); check("a_xper_pre", x_period, 0);
    step(1); check("a_xper", x_period, 99);
             check("a_busy_done", busy, 0);
    step(99); check("a_tick_pre", tick_x, 0);
    step(1);  check("a_tick1", tick_x, 1);
    step(1);  check("a_tick1_end", tick_x, 0);
    step(98); check("a_tick2_pre", tick_x, 0);
    step(1);  check("a_tick2", tick_x, 1);

    // B: both axes change together, X served first
    do_reset();
    check("b_rst_xper", x_period, 0);
    base = hs_count;
    x_mag = 8'd20; y_mag = 8'd50;
    step(9);  check("b_xper", x_period, 49);
              check("b_yper_pre", y_period, 0);
              check("b_first_div", hs_div[base], 20);
    step(1);  check("b_busy_y", busy, 1);
    step(7);  check("b_yper", y_period, 19);
              check("b_xper_keep", x_period, 49);
              check("b_second_div", hs_div[base + 1], 50);

    // C: tready stalled 5 cycles during ISSUE
    do_reset();
    base = hs_count;
    div_tready = 1'b0;
    x_mag = 8'd10;
    step(3); check("c_tvalid_s0", div_tvalid, 1); check("c_div_s0", div_divisor, 10);
    step(2); check("c_tvalid_s2", div_tvalid, 1); check("c_div_s2", div_divisor, 10);
    step(2); check("c_tvalid_s4", div_tvalid, 1); check("c_div_s4", div_divisor, 10);
             check("c_no_hs", hs_count - base, 0);
    div_tready = 1'b1;
    step(1); check("c_tvalid_hs", div_tvalid, 0);
             check("c_one_hs", hs_count - base, 1);
    step(5); check("c_xper", x_period, 99);
             check("c_one_hs_end", hs_count - base, 1);

    // D: magnitude changes during WAIT -> commit then reissue
    do_reset();
    base = hs_count;
    x_mag = 8'd10;
    step(5); x_mag = 8'd25;
    step(4); check("d_xper_first", x_period, 99);
    step(2); check("d_tvalid_re", div_tvalid, 1);
             check("d_div_re", div_divisor, 25);
    step(6); check("d_xper_final", x_period, 39);
             check("d_hs_cnt", hs_count - base, 2);
    step(1); check("d_busy_idle", busy, 0);

    // E: divider never answers -> timeout, error, retry
    do_reset();
    drop_result = 1'b1;
    x_mag = 8'd10;
    step(67); check("e_err_pre", div_error, 0);
              check("e_busy_wait", busy, 1);
    step(1);  check("e_err", div_error, 1);
              check("e_busy_to", busy, 0);
    step(2);  check("e_retry_tvalid", div_tvalid, 1);
              check("e_retry_div", div_divisor, 10);
    drop_result = 1'b0;
    step(6);  check("e_xper", x_period, 99);
              check("e_err_sticky", div_error, 1);

    // Stop value: period 0, no divide, ticks stop
    base = hs_count;
`ifdef MAG_DEADBAND_EN
    x_mag = 8'd8;
`else
    x_mag = 8'd0;
`endif
    step(2); check("s_xper", x_period, 0);
             check("s_busy", busy, 0);
    nticks = 0; nvalid = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (tick_x) nticks++;
      if (div_tvalid) nvalid++;
    end
    check("s_ticks", nticks, 0);
    check("s_tvalid", nvalid, 0);
    check("s_no_hs", hs_count - base, 0);

    // F: reset during WAIT, late result ignored
    do_reset();
    check("f_err_clr", div_error, 0);
    base = res_count;
    x_mag = 8'd10;
    step(5); check("f_busy_wait", busy, 1);
    reset = 1'b1; x_mag = '0;
    step(1); reset = 1'b0;
             check("f_busy_rst", busy, 0);
    step(4); check("f_late_seen", res_count - base, 1);
             check("f_xper", x_period, 0);
             check("f_yper", y_period, 0);
             check("f_busy", busy, 0);
             check("f_tvalid", div_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
